// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM encoding for the boot loader, CPU and RAM.
package prog_loader_pkg;

  // RAM geometry shared with the accumulator CPU and the 64x10 block RAM
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 10;

  // Header tags live in the bits above the address field
  localparam int TAG_W_DEF = DATA_W_DEF - ADDR_W_DEF;
  localparam logic [TAG_W_DEF-1:0] TAG_SYNC_MORE = 4'hA;
  localparam logic [TAG_W_DEF-1:0] TAG_SYNC_LAST = 4'hB;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_ram_port_mux.sv
// Selects who drives the single RAM port: the loader while booting, the CPU once running.
module prog_loader_ram_port_mux #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     sel_cpu,
  input  logic                     ld_we,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_din,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_din,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din
);

  // Purely combinational so CPU accesses reach the RAM in the same cycle
  always_comb begin
    ram_we   = ld_we;
    ram_addr = ld_addr;
    ram_din  = ld_din;
    if (sel_cpu) begin
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses framed stream, writes payload to RAM, verifies
// per-block checksum, then hands the RAM port to the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter logic [DATA_WIDTH-ADDRESS_WIDTH-1:0] SYNC_MORE = TAG_SYNC_MORE,
  parameter logic [DATA_WIDTH-ADDRESS_WIDTH-1:0] SYNC_LAST = TAG_SYNC_LAST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_din,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     cpu_rst,
  output logic                     boot_done,
  output logic                     boot_err,
  output logic [ADDRESS_WIDTH:0]   words_loaded
);

  localparam int TW = DATA_WIDTH - ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] WL_MAX = '1;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] base, ptr, cnt;
  logic                     last;
  logic [DATA_WIDTH-1:0]    sum;
  logic                     ld_we;
  logic [ADDRESS_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0]    ld_din;
  logic [TW-1:0]            tag;
  logic                     is_sync;
  logic                     acc;

  // Ready depends only on the state register, never on in_valid
  assign in_ready  = (state != ST_RUN) && (state != ST_ERR);
  assign acc       = in_valid && in_ready;
  assign tag       = in_data[DATA_WIDTH-1:ADDRESS_WIDTH];
  assign is_sync   = (tag == SYNC_MORE) || (tag == SYNC_LAST);
  assign boot_done = (state == ST_RUN);
  assign boot_err  = (state == ST_ERR);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_HDR;
    else     state <= state_nxt;
  end

  // Frame parser transitions; RUN and ERR hold until reset
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR:  if (acc && is_sync) state_nxt = ST_LEN;
      ST_LEN:  if (acc) state_nxt = ST_DATA;
      ST_DATA: if (acc && cnt == '0) state_nxt = ST_CSUM;
      ST_CSUM: if (acc) state_nxt = (in_data != sum) ? ST_ERR :
                                    (last ? ST_RUN : ST_HDR);
      default: state_nxt = state;
    endcase
  end

  // Datapath: header/length latches, write pointer, checksum, registered RAM write
  always_ff @(posedge clk) begin
    if (rst) begin
      base         <= '0;
      last         <= 1'b0;
      sum          <= '0;
      ptr          <= '0;
      cnt          <= '0;
      ld_we        <= 1'b0;
      ld_addr      <= '0;
      ld_din       <= '0;
      words_loaded <= '0;
      cpu_rst      <= 1'b1;
    end else begin
      ld_we   <= 1'b0;
      // Falls on the edge entering RUN, a cycle after the final write is presented
      cpu_rst <= (state_nxt != ST_RUN);
      if (acc) begin
        case (state)
          ST_HDR: if (is_sync) begin
            base <= in_data[ADDRESS_WIDTH-1:0];
            last <= (tag == SYNC_LAST);
            sum  <= '0;
          end
          ST_LEN: begin
            cnt <= in_data[ADDRESS_WIDTH-1:0];
            ptr <= base;
          end
          ST_DATA: begin
            ld_we   <= 1'b1;
            ld_addr <= ptr;
            ld_din  <= in_data;
            ptr     <= ptr + 1'b1;
            sum     <= sum + in_data;
            if (words_loaded != WL_MAX) words_loaded <= words_loaded + 1'b1;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  prog_loader_ram_port_mux #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_mux (
    .sel_cpu (boot_done),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_din  (ld_din),
    .cpu_we  (cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .ram_we  (ram_we),
    .ram_addr(ram_addr),
    .ram_din (ram_din)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level reference model plus an attached RAM.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_ready;
  logic       cpu_we = 1'b0;
  logic [5:0] cpu_addr = '0;
  logic [9:0] cpu_din = '0;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [9:0] ram_din;
  logic       cpu_rst, boot_done, boot_err;
  logic [6:0] words_loaded;

  prog_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .cpu_rst(cpu_rst), .boot_done(boot_done), .boot_err(boot_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // The RAM the loader feeds
  logic [9:0] tb_ram [64];
  always @(posedge clk) if (ram_we) tb_ram[ram_addr] <= ram_din;

  // Reference model: expected RAM image and payload count
  logic [9:0] model_ram [64];
  int         model_wl;
  int         checks = 0;
  int         errors = 0;
  bit         gap_en = 1'b0;

  // Pending stream: word, whether it is payload, and its expected address
  logic [9:0] words_q [$];
  bit         isd_q [$];
  logic [5:0] addr_q [$];

  task automatic push_word(input logic [9:0] w, input bit d, input logic [5:0] a);
    words_q.push_back(w);
    isd_q.push_back(d);
    addr_q.push_back(a);
    if (d) begin
      model_ram[a] = w;
      if (model_wl < 127) model_wl++;
    end
  endtask

  // Whole frame from the format rules: header, length, N words, sum of words mod 1024
  task automatic build_frame(input logic [3:0] tag, input logic [5:0] base, input int n,
                             input bit corrupt);
    logic [9:0] s, w;
    logic [5:0] a;
    s = '0;
    a = base;
    push_word({tag, base}, 1'b0, 6'd0);
    push_word({4'($urandom), 6'(n - 1)}, 1'b0, 6'd0);
    for (int i = 0; i < n; i++) begin
      w = 10'($urandom);
      push_word(w, 1'b1, a);
      s = s + w;
      a = a + 6'd1;
    end
    push_word(corrupt ? (s ^ 10'h001) : s, 1'b0, 6'd0);
  endtask

  // Drives one word (optionally after idle gaps) and checks the write it should cause
  task automatic send_word(input logic [9:0] w, input bit d, input logic [5:0] a);
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 10'($urandom);
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 1'b0) begin
          errors++;
          $display("FAIL idle_we: ram_we=%b expected 0", ram_we);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready: in_ready=%b expected 1 for word %h", in_ready, w);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    checks++;
    if (d) begin
      if (ram_we !== 1'b1 || ram_addr !== a || ram_din !== w || cpu_rst !== 1'b1) begin
        errors++;
        $display("FAIL data_write: we=%b addr=%0d din=%h cpu_rst=%b expected we=1 addr=%0d din=%h cpu_rst=1",
                 ram_we, ram_addr, ram_din, cpu_rst, a, w);
      end
    end else if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_write: ram_we=%b expected 0 after word %h", ram_we, w);
    end
  endtask

  task automatic send_all();
    while (words_q.size() > 0) send_word(words_q.pop_front(), isd_q.pop_front(), addr_q.pop_front());
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    cpu_we   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    model_wl = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 6'd0 || ram_din !== 10'd0 || cpu_rst !== 1'b1 ||
        boot_done !== 1'b0 || boot_err !== 1'b0 || words_loaded !== 7'd0) begin
      errors++;
      $display("FAIL reset_vals: we=%b addr=%0d din=%h cpu_rst=%b done=%b err=%b wl=%0d expected 0,0,0,1,0,0,0",
               ram_we, ram_addr, ram_din, cpu_rst, boot_done, boot_err, words_loaded);
    end
    @(negedge clk);
    rst = 1'b0;
    model_wl = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b cpu_rst=%b expected 1,1", in_ready, cpu_rst);
    end
  endtask

  task automatic test_two_block();
    do_reset();
    gap_en = 1'b0;
    push_word(10'h280, 0, 0); push_word(10'h003, 0, 0);
    push_word(10'h032, 1, 0); push_word(10'h0B3, 1, 1);
    push_word(10'h074, 1, 2); push_word(10'h240, 1, 3);
    push_word(10'h399, 0, 0);
    push_word(10'h2F2, 0, 0); push_word(10'h001, 0, 0);
    push_word(10'h005, 1, 50); push_word(10'h00A, 1, 51);
    push_word(10'h00F, 0, 0);
    send_all();
    checks++;
    if (cpu_rst !== 1'b0 || boot_done !== 1'b1 || boot_err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL two_block_status: cpu_rst=%b done=%b err=%b ready=%b expected 0,1,0,0",
               cpu_rst, boot_done, boot_err, in_ready);
    end
    checks++;
    if (words_loaded !== 7'd6) begin
      errors++;
      $display("FAIL two_block_wl: words_loaded=%0d expected 6", words_loaded);
    end
    // CPU program stores its result at 52 once running
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 6'd52; cpu_din = 10'h00F;
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 6'd52 || ram_din !== 10'h00F) begin
      errors++;
      $display("FAIL cpu_pass: we=%b addr=%0d din=%h expected 1,52,00f", ram_we, ram_addr, ram_din);
    end
    @(posedge clk);
    model_ram[52] = 10'h00F;
    @(negedge clk);
    cpu_we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (tb_ram[i] !== model_ram[i]) begin
        errors++;
        $display("FAIL two_block_ram[%0d]: got %h expected %h", i, tb_ram[i], model_ram[i]);
      end
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    push_word(10'h2C0, 0, 0); push_word(10'h000, 0, 0);
    push_word(10'h155, 1, 0); push_word(10'h154, 0, 0);
    send_all();
    checks++;
    if (boot_err !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum_status: err=%b cpu_rst=%b ready=%b done=%b expected 1,1,0,0",
               boot_err, cpu_rst, in_ready, boot_done);
    end
    // Stream and CPU traffic must both be ignored in the error state
    @(negedge clk);
    in_valid = 1'b1; in_data = 10'h280;
    cpu_we = 1'b1; cpu_addr = 6'd5; cpu_din = 10'h3FF;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (ram_we !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 7'd1 || boot_err !== 1'b1) begin
        errors++;
        $display("FAIL err_hold: we=%b ready=%b wl=%0d err=%b expected 0,0,1,1",
                 ram_we, in_ready, words_loaded, boot_err);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; cpu_we = 1'b0;
    checks++;
    if (tb_ram[0] !== 10'h155 || tb_ram[5] !== model_ram[5]) begin
      errors++;
      $display("FAIL bad_csum_ram: ram[0]=%h ram[5]=%h expected 155,%h", tb_ram[0], tb_ram[5], model_ram[5]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    push_word(10'h2FE, 0, 0); push_word(10'h003, 0, 0);
    push_word(10'd1, 1, 62); push_word(10'd2, 1, 63);
    push_word(10'd3, 1, 0);  push_word(10'd4, 1, 1);
    push_word(10'h00A, 0, 0);
    send_all();
    checks++;
    if (boot_done !== 1'b1 || words_loaded !== 7'd4) begin
      errors++;
      $display("FAIL wrap_status: done=%b wl=%0d expected 1,4", boot_done, words_loaded);
    end
    checks++;
    if (tb_ram[62] !== 10'd1 || tb_ram[63] !== 10'd2 || tb_ram[0] !== 10'd3 || tb_ram[1] !== 10'd4) begin
      errors++;
      $display("FAIL wrap_ram: %h %h %h %h expected 001 002 003 004",
               tb_ram[62], tb_ram[63], tb_ram[0], tb_ram[1]);
    end
  endtask

  task automatic test_garbage();
    do_reset();
    push_word(10'h3FF, 0, 0);
    push_word(10'h000, 0, 0);
    build_frame(4'hB, 6'($urandom), $urandom_range(1, 16), 1'b0);
    send_all();
    checks++;
    if (boot_done !== 1'b1 || boot_err !== 1'b0 || words_loaded !== 7'(model_wl)) begin
      errors++;
      $display("FAIL garbage_status: done=%b err=%b wl=%0d expected 1,0,%0d",
               boot_done, boot_err, words_loaded, model_wl);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (tb_ram[i] !== model_ram[i]) begin
        errors++;
        $display("FAIL garbage_ram[%0d]: got %h expected %h", i, tb_ram[i], model_ram[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gap_en = 1'b1;
    build_frame(4'hA, 6'($urandom), $urandom_range(43, 64), 1'b0);
    build_frame(4'hA, 6'($urandom), $urandom_range(43, 64), 1'b0);
    build_frame(4'hB, 6'($urandom), $urandom_range(43, 64), 1'b0);
    send_all();
    gap_en = 1'b0;
    checks++;
    if (boot_done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 7'd127 || model_wl != 127) begin
      errors++;
      $display("FAIL b2b_status: done=%b cpu_rst=%b wl=%0d expected 1,0,127",
               boot_done, cpu_rst, words_loaded);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (tb_ram[i] !== model_ram[i]) begin
        errors++;
        $display("FAIL b2b_ram[%0d]: got %h expected %h", i, tb_ram[i], model_ram[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] b;
    logic       we;
    logic [5:0] a;
    logic [9:0] dd;
    do_reset();
    b = 6'($urandom);
    push_word({4'hA, b}, 0, 0);
    push_word(10'h007, 0, 0);
    for (int i = 0; i < 3; i++) push_word(10'($urandom), 1, b + 6'(i));
    while (words_q.size() > 0) send_word(words_q.pop_front(), isd_q.pop_front(), addr_q.pop_front());
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || cpu_rst !== 1'b1 || boot_done !== 1'b0 || boot_err !== 1'b0 ||
        words_loaded !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b cpu_rst=%b done=%b err=%b wl=%0d expected 1,1,0,0,0",
               in_ready, cpu_rst, boot_done, boot_err, words_loaded);
    end
    build_frame(4'hB, 6'($urandom), $urandom_range(1, 20), 1'b0);
    send_all();
    checks++;
    if (boot_done !== 1'b1 || words_loaded !== 7'(model_wl)) begin
      errors++;
      $display("FAIL mid_reset_reload: done=%b wl=%0d expected 1,%0d", boot_done, words_loaded, model_wl);
    end
    // Random CPU traffic must pass straight through
    repeat (6) begin
      we = 1'($urandom); a = 6'($urandom); dd = 10'($urandom);
      @(negedge clk);
      cpu_we = we; cpu_addr = a; cpu_din = dd;
      #1;
      checks++;
      if (ram_we !== we || ram_addr !== a || ram_din !== dd) begin
        errors++;
        $display("FAIL cpu_mux: we=%b addr=%0d din=%h expected %b,%0d,%h", ram_we, ram_addr, ram_din, we, a, dd);
      end
      @(posedge clk);
      if (we) model_ram[a] = dd;
    end
    @(negedge clk);
    cpu_we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (tb_ram[i] !== model_ram[i]) begin
        errors++;
        $display("FAIL mid_reset_ram[%0d]: got %h expected %h", i, tb_ram[i], model_ram[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      tb_ram[i]    = '0;
      model_ram[i] = '0;
    end
    model_wl = 0;
    test_reset();
    test_two_block();
    test_bad_csum();
    test_wrap();
    test_garbage();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
